// File: rtl/mtimer.sv
// mtimer: memory-mapped 64-bit machine timer with compare interrupt and atomic hi-word snapshot.
// Optional prescaler enabled by defining MTIMER_PRESCALER_EN.
module mtimer #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            we_i,
  output logic [31:0]           rdata_o,
  output logic                  irq_o
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state;
  logic [63:0] mtime, mtimecmp, mtime_inc;
  logic [31:0] hi_snap, ctrl_rd, rd_mux, lo_next, hi_next;
  logic [2:0] sel;
  logic en, ie, tick, pend, acc, wr, rd, wlo, whi, wctrl;
  logic unused;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  assign unused    = ^{addr_i[ADDR_WIDTH-1:5], addr_i[1:0]};
  assign sel       = addr_i[4:2];
  assign acc       = state == IDLE && valid_i;
  assign wr        = acc && |we_i;
  assign rd        = acc && ~|we_i;
  assign wlo       = wr && sel == 3'd0;
  assign whi       = wr && sel == 3'd1;
  assign wctrl     = wr && sel == 3'd4;
  assign pend      = mtime >= mtimecmp;
  assign mtime_inc = mtime + 64'd1;
  // a written word freezes the other word's carry path for that cycle
  assign lo_next   = wlo ? merge(mtime[31:0], wdata_i, we_i) : tick ? mtime_inc[31:0] : mtime[31:0];
  assign hi_next   = whi ? merge(mtime[63:32], wdata_i, we_i) : (tick && !wlo) ? mtime_inc[63:32] : mtime[63:32];

`ifdef MTIMER_PRESCALER_EN
  logic [7:0] presc, pcnt;
  assign tick    = en && pcnt == presc;
  assign ctrl_rd = {16'd0, presc, 6'd0, ie, en};
  always_ff @(posedge clk)
    if (!rst_n) begin
      presc <= 8'd0;
      pcnt  <= 8'd0;
    end else begin
      if (wctrl && we_i[1]) presc <= wdata_i[15:8];
      pcnt <= (!en || wctrl || tick) ? 8'd0 : pcnt + 8'd1;
    end
`else
  assign tick    = en;
  assign ctrl_rd = {30'd0, ie, en};
`endif

  always_comb begin
    rd_mux = 32'd0;
    case (sel)
      3'd0: rd_mux = mtime[31:0];
      3'd1: rd_mux = hi_snap;
      3'd2: rd_mux = mtimecmp[31:0];
      3'd3: rd_mux = mtimecmp[63:32];
      3'd4: rd_mux = ctrl_rd;
      3'd5: rd_mux = {31'd0, pend};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      state    <= IDLE;
      ready_o  <= 1'b0;
      rdata_o  <= 32'd0;
      irq_o    <= 1'b0;
      mtime    <= 64'd0;
      mtimecmp <= '1;
      hi_snap  <= 32'd0;
      en       <= 1'b0;
      ie       <= 1'b0;
    end else begin
      state   <= acc ? RESP : IDLE;
      ready_o <= acc;
      irq_o   <= ie & pend;
      mtime   <= {hi_next, lo_next};
      if (acc) rdata_o <= rd_mux;
      if (rd && sel == 3'd0) hi_snap <= mtime[63:32];
      if (whi) hi_snap <= hi_next;
      if (wr && sel == 3'd2) mtimecmp[31:0] <= merge(mtimecmp[31:0], wdata_i, we_i);
      if (wr && sel == 3'd3) mtimecmp[63:32] <= merge(mtimecmp[63:32], wdata_i, we_i);
      if (wctrl && we_i[0]) {ie, en} <= wdata_i[1:0];
    end
endmodule

// File: tb/tb_mtimer.sv
// tb_mtimer: scoreboard bench for mtimer; stimulus tasks queue expectations, a monitor checks on ready_o.
module tb_mtimer;
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0, rdata;
  logic [3:0] we = 4'd0;
  logic ready, irq;
  int total = 0, bad = 0;
  typedef struct {logic chk; logic [31:0] val; string name;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] rst_exp [8] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [5:0] pat;
  int n;

  always #5 clk = ~clk;

  mtimer dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .ready_o(ready), .addr_i(addr),
    .wdata_i(wdata), .we_i(we), .rdata_o(rdata), .irq_o(irq)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk)
    if (ready === 1'b1) begin
      if (q.size() == 0) check("unexpected_ready", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        if (e.chk) check(e.name, rdata, e.val);
      end
    end

  task automatic access(input string name, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] w, input logic [31:0] exp, input logic chk);
    int k;
    q.push_back('{chk, exp, name});
    addr = a; wdata = d; we = w; valid = 1'b1;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (ready !== 1'b1 && k < 8);
    check({name, "_latency"}, k, 1);
    if (ready !== 1'b1) void'(q.pop_back());
    valid = 1'b0; we = 4'd0;
    @(posedge clk); #1;
    check({name, "_pulse"}, {31'd0, ready}, 0);
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    access(name, a, 32'd0, 4'd0, exp, 1'b1);
  endtask

  task automatic wr(input string name, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    access(name, a, d, w, 32'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 0);
    check("rst_irq", {31'd0, irq}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) rd($sformatf("rst_off%0d", i), i * 4, rst_exp[i]);
    // carry from low into high word, then atomic LO/HI pair
    wr("w_lo", 32'h0, 32'hFFFFFFFE, 4'hF);
    wr("w_hi", 32'h4, 32'h0, 4'hF);
    wr("w_ctrl_en", 32'h10, 32'h1, 4'hF);
    repeat (4) @(posedge clk);
    #1;
    rd("carry_lo", 32'h0, 32'h3);
    rd("carry_hi_snap", 32'h4, 32'h1);
    // compare and interrupt timing
    wr("stop", 32'h10, 32'h0, 4'hF);
    wr("cmp_lo", 32'h8, 32'd100, 4'hF);
    wr("cmp_hi", 32'hC, 32'h0, 4'hF);
    wr("clr_lo", 32'h0, 32'h0, 4'hF);
    wr("clr_hi", 32'h4, 32'h0, 4'hF);
    wr("ctrl_en_ie", 32'h10, 32'h3, 4'hF);
    n = 0;
    while (irq !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    check("irq_rise_cycles", n, 100);
    rd("status_pend", 32'h14, 32'h1);
    wr("cmp_hi_raise", 32'hC, 32'h1, 4'hF);
    check("irq_fall", {31'd0, irq}, 0);
    rd("status_clear", 32'h14, 32'h0);
    // reset during a pending write aborts it
    rst_n = 1'b0;
    addr = 32'h10; wdata = 32'h1; we = 4'hF; valid = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", {31'd0, ready}, 0);
    valid = 1'b0; we = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd("abort_ctrl", 32'h10, 32'h0);
    rd("abort_cmp_hi", 32'hC, 32'hFFFFFFFF);
    wr("byte_wr", 32'h8, 32'h0000AB00, 4'b0010);
    rd("byte_rd", 32'h8, 32'hFFFFABFF);
    wr("unmapped_wr", 32'h18, 32'h12345678, 4'hF);
    rd("unmapped_rd", 32'h18, 32'h0);
    // three requests with valid held high
    for (int i = 0; i < 3; i++) q.push_back('{1'b1, 32'hFFFFABFF, $sformatf("b2b%0d", i)});
    addr = 32'h8; we = 4'd0; valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pat[i] = ready;
      if (i == 4) valid = 1'b0;
    end
    check("b2b_pattern", {26'd0, pat}, 32'b010101);
    wr("presc_ctrl", 32'h10, 32'h0301, 4'hF);
`ifdef MTIMER_PRESCALER_EN
    rd("presc_ctrl_rd", 32'h10, 32'h0301);
    rd("presc_lo1", 32'h0, 32'h0);
    rd("presc_lo2", 32'h0, 32'h1);
`else
    rd("presc_ctrl_rd", 32'h10, 32'h1);
    rd("presc_lo1", 32'h0, 32'h3);
    rd("presc_lo2", 32'h0, 32'h5);
`endif
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
